// File: rtl/stm_width_split_pkg.sv
// Shared definitions for the wide-to-narrow AXI-stream splitter (stm_width_split).
//   BitWidth()        index width helper (never returns 0)
//   I_WIDTH_DEF etc.  default widths; R, O_UINT, I_UINT derived from them
//   stm_split_st_e    splitter state encoding
//   stm_split_hold_s  holding-register layout at the default widths
package stm_pkg;

  function automatic int unsigned BitWidth(input int unsigned n);
    return (n <= 1) ? 1 : $unsigned($clog2(n));
  endfunction

  localparam int unsigned I_WIDTH_DEF    = 64 * 8;
  localparam int unsigned O_WIDTH_DEF    = 4 * 8;
  localparam int unsigned WORD_WIDTH_DEF = 8;

  localparam int unsigned R      = I_WIDTH_DEF / O_WIDTH_DEF;
  localparam int unsigned O_UINT = O_WIDTH_DEF / WORD_WIDTH_DEF;
  localparam int unsigned I_UINT = I_WIDTH_DEF / WORD_WIDTH_DEF;

  typedef enum logic {
    EMPTY = 1'b0,
    LOAD  = 1'b1
  } stm_split_st_e;

  typedef struct packed {
    logic [I_WIDTH_DEF-1:0] data;
    logic [I_UINT-1:0]      keep;
    logic                   last;
    logic                   user;
    logic [R-1:0]           mask;
  } stm_split_hold_s;

endpackage

// File: rtl/stm_width_split_if.sv
// AXI-stream bundle used on both sides of stm_width_split.
//   DATA_W  tdata width, KEEP_W tkeep width
//   master: drives tdata/tkeep/tlast/tvld/tuser, receives trdy
//   slave : receives tdata/tkeep/tlast/tvld/tuser, drives trdy
interface stm_width_split_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = 4
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvld;
  logic              tuser;
  logic              trdy;

  modport master (output tdata, tkeep, tlast, tvld, tuser, input trdy);
  modport slave  (input tdata, tkeep, tlast, tvld, tuser, output trdy);
endinterface

// File: rtl/stm_width_split_prio_enc.sv
// Lowest-index priority encoder (combinational).
//   i_req     N-bit request vector
//   o_onehot  lowest set request bit, one-hot
//   o_idx     binary index of that bit
//   o_single  at most one request bit is set
module stm_prio_enc
  import stm_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]             i_req,
  output logic [N-1:0]             o_onehot,
  output logic [BitWidth(N)-1:0]   o_idx,
  output logic                     o_single
);
  localparam int unsigned IW = BitWidth(N);

  logic w_found;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !w_found) begin
        w_found     = 1'b1;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
      end
    end
  end

  assign o_single = ((i_req & (i_req - N'(1))) == '0);

endmodule

// File: rtl/stm_width_split.sv
// Wide-to-narrow AXI-stream splitter. Each accepted wide beat is cut into
// O_WIDTH slices, LSB first; slices without any kept word are skipped, and
// tkeep/tlast/tuser are rebuilt per slice.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   s_axis          wide input stream (slave modport)
//   m_axis          narrow output stream (master modport)
//   o_keep_err      sticky non-contiguous tkeep flag; only built with
//                   STM_WIDTH_SPLIT_KEEP_CHK_EN defined, tied 0 otherwise
module stm_width_split
  import stm_pkg::*;
#(
  parameter int unsigned I_WIDTH    = I_WIDTH_DEF,
  parameter int unsigned O_WIDTH    = O_WIDTH_DEF,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  stm_width_split_if.slave     s_axis,
  stm_width_split_if.master    m_axis,
  output logic                 o_keep_err
);
  localparam int unsigned P_R  = I_WIDTH / O_WIDTH;
  localparam int unsigned P_OU = O_WIDTH / WORD_WIDTH;
  localparam int unsigned P_IU = I_WIDTH / WORD_WIDTH;
  localparam int unsigned P_IW = BitWidth(P_R);

  typedef struct packed {
    logic [I_WIDTH-1:0] data;
    logic [P_IU-1:0]    keep;
    logic               last;
    logic               user;
    logic [P_R-1:0]     mask;
  } hold_t;

  stm_split_st_e r_state, w_nxt_state;
  hold_t         r_hold, w_nxt_hold;

  logic [O_WIDTH-1:0] r_m_data, w_nxt_m_data;
  logic [P_OU-1:0]    r_m_keep, w_nxt_m_keep;
  logic               r_m_last, w_nxt_m_last;
  logic               r_m_user, w_nxt_m_user;
  logic               r_m_vld,  w_nxt_m_vld;

  logic [P_R-1:0]  w_onehot, w_new_mask;
  logic [P_IW-1:0] w_idx;
  logic            w_single, w_adv, w_emit, w_s_trdy, w_s_hs, w_load;

  stm_prio_enc #(.N(P_R)) u_prio (
    .i_req    (r_hold.mask),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_single (w_single)
  );

  // An all-zero keep beat that closes a packet still needs one slice to carry
  // tlast downstream, so it is given slice 0 with empty keep.
  always_comb begin
    w_new_mask = '0;
    for (int unsigned k = 0; k < P_R; k++)
      w_new_mask[k] = |s_axis.tkeep[k*P_OU +: P_OU];
    if ((w_new_mask == '0) && s_axis.tlast)
      w_new_mask[0] = 1'b1;
  end

  assign w_adv    = !r_m_vld || m_axis.trdy;
  assign w_emit   = (r_state == LOAD) && w_adv;
  // Accept when idle, or when the final slice leaves this cycle so the next
  // beat refills the holding register without a bubble.
  assign w_s_trdy = i_rst_n && ((r_state == EMPTY) || (w_single && w_emit));
  assign w_s_hs   = s_axis.tvld && w_s_trdy;
  assign w_load   = w_s_hs && (w_new_mask != '0);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_hold   = r_hold;
    w_nxt_m_data = r_m_data;
    w_nxt_m_keep = r_m_keep;
    w_nxt_m_last = r_m_last;
    w_nxt_m_user = r_m_user;
    w_nxt_m_vld  = r_m_vld;

    if (w_adv)
      w_nxt_m_vld = w_emit;

    if (w_emit) begin
      for (int unsigned k = 0; k < P_R; k++) begin
        if (P_IW'(k) == w_idx) begin
          w_nxt_m_data = r_hold.data[k*O_WIDTH +: O_WIDTH];
          w_nxt_m_keep = r_hold.keep[k*P_OU +: P_OU];
        end
      end
      w_nxt_m_last    = r_hold.last && w_single;
      w_nxt_m_user    = r_hold.user;
      w_nxt_hold.mask = r_hold.mask & ~w_onehot;
      w_nxt_hold.user = 1'b0;   // tuser only on the first emitted slice
      if (w_single)
        w_nxt_state = EMPTY;
    end

    if (w_load) begin
      w_nxt_hold.data = s_axis.tdata;
      w_nxt_hold.keep = s_axis.tkeep;
      w_nxt_hold.last = s_axis.tlast;
      w_nxt_hold.user = s_axis.tuser;
      w_nxt_hold.mask = w_new_mask;
      w_nxt_state     = LOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= EMPTY;
    else          r_state <= w_nxt_state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold   <= '0;
      r_m_data <= '0;
      r_m_keep <= '0;
      r_m_last <= 1'b0;
      r_m_user <= 1'b0;
      r_m_vld  <= 1'b0;
    end else begin
      r_hold   <= w_nxt_hold;
      r_m_data <= w_nxt_m_data;
      r_m_keep <= w_nxt_m_keep;
      r_m_last <= w_nxt_m_last;
      r_m_user <= w_nxt_m_user;
      r_m_vld  <= w_nxt_m_vld;
    end
  end

  assign s_axis.trdy  = w_s_trdy;
  assign m_axis.tdata = r_m_data;
  assign m_axis.tkeep = r_m_keep;
  assign m_axis.tlast = r_m_last;
  assign m_axis.tuser = r_m_user;
  assign m_axis.tvld  = r_m_vld;

`ifdef STM_WIDTH_SPLIT_KEEP_CHK_EN
  logic r_keep_err;

  // keep & (keep+1) is non-zero exactly when a 1 sits above a 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_keep_err <= 1'b0;
    else if (w_s_hs && ((s_axis.tkeep & (s_axis.tkeep + P_IU'(1))) != '0))
      r_keep_err <= 1'b1;
  end

  assign o_keep_err = r_keep_err;
`else
  assign o_keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_stm_width_split.sv
module tb_stm_width_split;
  import stm_pkg::*;

`ifdef STM_WIDTH_SPLIT_KEEP_CHK_EN
  localparam logic KCHK = 1'b1;
`else
  localparam logic KCHK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic keep_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edges  = 0;

  typedef struct {
    logic [7:0]  d;
    logic        k;
    logic        l;
    logic        u;
    int unsigned e;
  } cap_t;

  cap_t        q[$];
  bit          pat[$];
  bit          s_hs;
  bit          stalled;
  logic [11:0] prev;
  int unsigned acc1, acc2;

  stm_width_split_if #(.DATA_W(32), .KEEP_W(4)) s_if ();
  stm_width_split_if #(.DATA_W(8),  .KEEP_W(1)) m_if ();

  stm_width_split #(.I_WIDTH(32), .O_WIDTH(8), .WORD_WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .o_keep_err (keep_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive m_trdy, sample at negedge, advance past the posedge.
  task automatic tick();
    cap_t        c;
    logic [11:0] cur;
    m_if.trdy = (pat.size() > 0) ? pat.pop_front() : 1'b1;
    @(negedge clk);
    cur = {m_if.tvld, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
    if (stalled) chk("stall_stable", 64'(cur), 64'(prev));
    stalled = m_if.tvld && !m_if.trdy;
    prev    = cur;
    if (m_if.tvld && m_if.trdy) begin
      c.d = m_if.tdata; c.k = m_if.tkeep; c.l = m_if.tlast; c.u = m_if.tuser; c.e = edges;
      q.push_back(c);
    end
    s_hs = s_if.tvld && s_if.trdy;
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                      input logic u, output int unsigned acc);
    bit ok;
    ok  = 1'b0;
    acc = 0;
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tuser = u; s_if.tvld = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (s_hs) begin
        ok  = 1'b1;
        acc = edges;
      end
    end
    s_if.tvld = 1'b0;
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic chk_slice(input string tag, input int unsigned i, input logic [7:0] d,
                           input logic k, input logic l, input logic u);
    if (i < q.size()) chk(tag, 64'({q[i].d, q[i].k, q[i].l, q[i].u}), 64'({d, k, l, u}));
    else              chk({tag, "_missing"}, 64'(q.size()), 64'(i + 1));
  endtask

  initial begin
    rst_n = 1'b0;
    s_if.tvld = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.trdy = 1'b1;
    stalled = 1'b0;
    prev = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_vld", 64'(m_if.tvld), 64'd0);
    chk("rst_s_trdy_in_reset", 64'(s_if.trdy), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_s_trdy", 64'(s_if.trdy), 64'd1);
    chk("rst_m_outs", 64'({m_if.tvld, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}), 64'd0);
    chk("rst_keep_err", 64'(keep_err), 64'd0);

    // 1: two full beats, back-to-back slices, 1-edge latency
    q.delete();
    send(32'h44332211, 4'hF, 1'b0, 1'b0, acc1);
    send(32'h88776655, 4'hF, 1'b1, 1'b0, acc2);
    idle(6);
    chk("t1_second_accept_gap", 64'(acc2 - acc1), 64'd4);
    chk("t1_count", 64'(q.size()), 64'd8);
    chk_slice("t1_s0", 0, 8'h11, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s1", 1, 8'h22, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s2", 2, 8'h33, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s3", 3, 8'h44, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s4", 4, 8'h55, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s5", 5, 8'h66, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s6", 6, 8'h77, 1'b1, 1'b0, 1'b0);
    chk_slice("t1_s7", 7, 8'h88, 1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 8; i++)
      if (i < q.size()) chk($sformatf("t1_edge%0d", i), 64'(q[i].e), 64'(acc1 + 1 + i));

    // 2: trimmed last beat
    q.delete();
    send(32'hDDCCBBAA, 4'h3, 1'b1, 1'b0, acc1);
    idle(4);
    chk("t2_count", 64'(q.size()), 64'd2);
    chk_slice("t2_s0", 0, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk_slice("t2_s1", 1, 8'hBB, 1'b1, 1'b1, 1'b0);

    // 3: downstream toggling ready; second beat waits for the last slice
    q.delete();
    send(32'h0D0C0B0A, 4'hF, 1'b1, 1'b0, acc1);
    for (int i = 0; i < 4; i++) begin
      pat.push_back(1'b1);
      pat.push_back(1'b0);
    end
    send(32'h1E1D1C1B, 4'hF, 1'b1, 1'b0, acc2);
    idle(8);
    chk("t3_accept_gap", 64'(acc2 - acc1), 64'd7);
    chk("t3_count", 64'(q.size()), 64'd8);
    chk_slice("t3_a0", 0, 8'h0A, 1'b1, 1'b0, 1'b0);
    chk_slice("t3_a1", 1, 8'h0B, 1'b1, 1'b0, 1'b0);
    chk_slice("t3_a2", 2, 8'h0C, 1'b1, 1'b0, 1'b0);
    chk_slice("t3_a3", 3, 8'h0D, 1'b1, 1'b1, 1'b0);
    chk_slice("t3_b0", 4, 8'h1B, 1'b1, 1'b0, 1'b0);
    chk_slice("t3_b3", 7, 8'h1E, 1'b1, 1'b1, 1'b0);

    // 4: empty keep without / with last
    q.delete();
    send(32'hCAFEBABE, 4'h0, 1'b0, 1'b0, acc1);
    idle(4);
    chk("t4_drop_count", 64'(q.size()), 64'd0);
    chk("t4_drop_vld", 64'(m_if.tvld), 64'd0);
    send(32'h12345678, 4'h0, 1'b1, 1'b0, acc1);
    idle(4);
    chk("t4_last_count", 64'(q.size()), 64'd1);
    chk_slice("t4_last_s0", 0, 8'h78, 1'b0, 1'b1, 1'b0);

    // 5: tuser only on the first emitted slice
    q.delete();
    send(32'hDDCCBBAA, 4'hC, 1'b1, 1'b1, acc1);
    idle(4);
    chk("t5_count", 64'(q.size()), 64'd2);
    chk_slice("t5_s0", 0, 8'hCC, 1'b1, 1'b0, 1'b1);
    chk_slice("t5_s1", 1, 8'hDD, 1'b1, 1'b1, 1'b0);

    // 6: reset mid-beat, then restart and keep checker
    q.delete();
    send(32'h04030201, 4'hF, 1'b1, 1'b0, acc1);
    for (int i = 0; i < 20 && q.size() < 2; i++) tick();
    chk("t6_pre_slices", 64'(q.size()), 64'd2);
    chk("t6_pre_data", 64'(m_if.tdata), 64'h03);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(m_if.tvld), 64'd0);
    chk("t6_rst_data", 64'(m_if.tdata), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stalled = 1'b0;
    #1;
    chk("t6_rel_trdy", 64'(s_if.trdy), 64'd1);
    chk("t6_rel_keep_err", 64'(keep_err), 64'd0);
    q.delete();
    send(32'h14131211, 4'hF, 1'b1, 1'b0, acc1);
    idle(6);
    chk("t6_count", 64'(q.size()), 64'd4);
    chk_slice("t6_s0", 0, 8'h11, 1'b1, 1'b0, 1'b0);
    chk_slice("t6_s3", 3, 8'h14, 1'b1, 1'b1, 1'b0);
    chk("t6_keep_err_clean", 64'(keep_err), 64'd0);

    q.delete();
    send(32'h00330011, 4'h5, 1'b1, 1'b0, acc1);
    idle(4);
    chk("t6_k5_count", 64'(q.size()), 64'd2);
    chk_slice("t6_k5_s0", 0, 8'h11, 1'b1, 1'b0, 1'b0);
    chk_slice("t6_k5_s1", 1, 8'h33, 1'b1, 1'b1, 1'b0);
    chk("t6_keep_err_set", 64'(keep_err), 64'(KCHK));
    q.delete();
    send(32'h00000099, 4'h1, 1'b1, 1'b0, acc1);
    idle(4);
    chk_slice("t6_after_s0", 0, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("t6_keep_err_sticky", 64'(keep_err), 64'(KCHK));
    chk("end_m_vld", 64'(m_if.tvld), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
